// File: rtl/cat_lock_pkg.sv
// Shared types and default sizing for the key-locked cat controller and its key provisioner.
package cat_lock_pkg;

  localparam int CAT_KEY_W    = 8;
  localparam int CAT_MAX_FAIL = 3;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    ARMED,
    LOCKOUT
  } kp_state_t;

endpackage

// File: rtl/cat_key_shreg.sv
// Serial key capture: MSB-first shift register with a bit counter.
// Shifting stops once KEY_W bits are held; o_full flags the frame as complete.
module cat_key_shreg #(
  parameter int KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_sdi,
  output logic [KEY_W-1:0] o_shreg,
  output logic             o_full
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  logic [KEY_W-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [KEY_W-1:0] w_shifted;
  logic             w_full;

  assign w_shifted[0] = i_sdi;
  for (genvar gi = 1; gi < KEY_W; gi++) begin : g_shift
    assign w_shifted[gi] = r_shreg[gi-1];
  end

  assign w_full = (r_bit_cnt == CNT_W'(KEY_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_clr) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift && !w_full) begin
      r_shreg   <= w_shifted;
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign o_shreg = r_shreg;
  assign o_full  = w_full;

endmodule

// File: rtl/cat_key_provisioner.sv
// Receives the unlock key serially, checks even parity, and presents it to the locked FSM.
// Key is forced to zero until a frame passes; MAX_FAIL consecutive failures lock out until reset.
module cat_key_provisioner
  import cat_lock_pkg::*;
#(
  parameter int KEY_W    = CAT_KEY_W,
  parameter int MAX_FAIL = CAT_MAX_FAIL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sdi,
  input  logic             key_bit_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ready,
  output logic             key_err,
  output logic             locked,
  output logic             busy
);

  kp_state_t        r_state;
  kp_state_t        w_state_next;
  logic [KEY_W-1:0] w_shreg;
  logic             w_full;
  logic             w_clr;
  logic             w_shift;
  logic             w_par_sample;
  logic             w_pass;
  logic [3:0]       w_fail_inc;
  logic             r_parity;
  logic [3:0]       r_fail_cnt;
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_ready;
  logic             r_key_err;
  logic             r_locked;
  logic             r_busy;

  cat_key_shreg #(
    .KEY_W (KEY_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_sdi   (key_sdi),
    .o_shreg (w_shreg),
    .o_full  (w_full)
  );

  assign w_pass     = ~(^w_shreg ^ r_parity);
  assign w_fail_inc = (r_fail_cnt >= 4'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // A start pulse always wins over a same-cycle strobe, except in CHECK and LOCKOUT.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_shift      = 1'b0;
    w_par_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_start) begin
          w_clr        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (key_start) begin
          w_clr = 1'b1;
        end else if (key_bit_vld) begin
          if (w_full) begin
            w_par_sample = 1'b1;
            w_state_next = CHECK;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      CHECK: begin
        if (w_pass)                          w_state_next = ARMED;
        else if (w_fail_inc >= 4'(MAX_FAIL)) w_state_next = LOCKOUT;
        else                                 w_state_next = IDLE;
      end
      ARMED: begin
        if (key_start) begin
          w_clr        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      LOCKOUT: begin
        w_state_next = LOCKOUT;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity    <= 1'b0;
      r_fail_cnt  <= 4'd0;
      r_key_out   <= '0;
      r_key_ready <= 1'b0;
      r_key_err   <= 1'b0;
      r_locked    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_par_sample) r_parity <= key_sdi;
      if (r_state == CHECK) r_fail_cnt <= w_pass ? 4'd0 : w_fail_inc;
      if (w_state_next != ARMED)  r_key_out <= '0;
      else if (r_state == CHECK)  r_key_out <= w_shreg;
      r_key_ready <= (w_state_next == ARMED);
      r_key_err   <= (r_state == CHECK) && !w_pass;
      r_locked    <= (w_state_next == LOCKOUT);
      r_busy      <= (w_state_next == SHIFT) || (w_state_next == CHECK);
    end
  end

  assign key_out   = r_key_out;
  assign key_ready = r_key_ready;
  assign key_err   = r_key_err;
  assign locked    = r_locked;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cat_key_provisioner.sv
// Directed bench for cat_key_provisioner: frame table plus restart, lockout,
// re-provision, start-during-check and asynchronous-reset sequences.
module tb_cat_key_provisioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0;
  logic       key_sdi = 1'b0;
  logic       key_bit_vld = 1'b0;
  logic [7:0] key_out;
  logic       key_ready;
  logic       key_err;
  logic       locked;
  logic       busy;

  int errors = 0;
  int checks = 0;

  cat_key_provisioner #(
    .KEY_W    (8),
    .MAX_FAIL (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_start   (key_start),
    .key_sdi     (key_sdi),
    .key_bit_vld (key_bit_vld),
    .key_out     (key_out),
    .key_ready   (key_ready),
    .key_err     (key_err),
    .locked      (locked),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic       par;
    int         gap;
    logic       exp_ok;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; key_start = 1'b0; key_bit_vld = 1'b0; key_sdi = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic start_pulse;
    key_start = 1'b1;
    tick;
    key_start = 1'b0;
  endtask

  task automatic shift_bits(input logic [7:0] k, input int n, input int gap);
    for (int i = 7; i > 7 - n; i--) begin
      key_bit_vld = 1'b0;
      repeat (gap) tick;
      key_bit_vld = 1'b1;
      key_sdi = k[i];
      tick;
    end
    key_bit_vld = 1'b0;
  endtask

  task automatic send_par(input logic p, input int gap);
    key_bit_vld = 1'b0;
    repeat (gap) tick;
    key_bit_vld = 1'b1;
    key_sdi = p;
    tick;
    key_bit_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] k, input logic p, input int gap);
    start_pulse;
    shift_bits(k, 8, gap);
    send_par(p, gap);
  endtask

  initial begin
    logic [3:0] exp_fail;

    vecs[0] = '{key: 8'hA5, par: 1'b0, gap: 0, exp_ok: 1'b1};
    vecs[1] = '{key: 8'hA5, par: 1'b1, gap: 0, exp_ok: 1'b0};
    vecs[2] = '{key: 8'h3C, par: 1'b0, gap: 2, exp_ok: 1'b1};
    vecs[3] = '{key: 8'h0F, par: 1'b0, gap: 1, exp_ok: 1'b1};
    vecs[4] = '{key: 8'h01, par: 1'b1, gap: 0, exp_ok: 1'b1};
    vecs[5] = '{key: 8'h01, par: 1'b0, gap: 0, exp_ok: 1'b0};
    vecs[6] = '{key: 8'hFF, par: 1'b0, gap: 1, exp_ok: 1'b1};
    vecs[7] = '{key: 8'h80, par: 1'b0, gap: 0, exp_ok: 1'b0};

    // Reset state while rst is held
    tick;
    chk("rst_key_out", 32'(key_out), 32'h0);
    chk("rst_key_ready", 32'(key_ready), 32'h0);
    chk("rst_key_err", 32'(key_err), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    do_reset;

    exp_fail = 4'd0;
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].key, vecs[v].par, vecs[v].gap);
      chk("vec_busy_check", 32'(busy), 32'h1);
      chk("vec_ready_early", 32'(key_ready), 32'h0);
      tick;
      exp_fail = vecs[v].exp_ok ? 4'd0 : exp_fail + 4'd1;
      chk("vec_ready", 32'(key_ready), 32'(vecs[v].exp_ok));
      chk("vec_key_out", 32'(key_out), vecs[v].exp_ok ? 32'(vecs[v].key) : 32'h0);
      chk("vec_err_pulse", 32'(key_err), 32'(!vecs[v].exp_ok));
      chk("vec_fail_cnt", 32'(dut.r_fail_cnt), 32'(exp_fail));
      tick;
      chk("vec_err_done", 32'(key_err), 32'h0);
      chk("vec_busy_done", 32'(busy), 32'h0);
      $display("vec %0d key=%02h par=%0d gap=%0d -> key_out=%02h ready=%0d locked=%0d",
               v, vecs[v].key, vecs[v].par, vecs[v].gap, key_out, key_ready, locked);
    end

    // Lockout after three consecutive parity failures
    do_reset;
    for (int n = 0; n < 3; n++) begin
      send_frame(8'hA5, 1'b1, 0);
      tick;
      chk("lock_err", 32'(key_err), 32'h1);
      chk("lock_locked", 32'(locked), (n == 2) ? 32'h1 : 32'h0);
      tick;
    end
    $display("lockout: three bad frames -> locked=%0d", locked);
    start_pulse;
    chk("lock_busy_start", 32'(busy), 32'h0);
    shift_bits(8'hA5, 8, 0);
    send_par(1'b0, 0);
    chk("lock_busy_par", 32'(busy), 32'h0);
    tick;
    chk("lock_key_out", 32'(key_out), 32'h0);
    chk("lock_ready", 32'(key_ready), 32'h0);
    chk("lock_held", 32'(locked), 32'h1);
    do_reset;
    chk("lock_rst_clear", 32'(locked), 32'h0);
    $display("lockout: good frame ignored, rst -> locked=%0d", locked);

    // Restart mid-frame; the strobe coinciding with start is discarded
    start_pulse;
    shift_bits(8'hFF, 4, 0);
    key_start = 1'b1; key_bit_vld = 1'b1; key_sdi = 1'b1;
    tick;
    key_start = 1'b0; key_bit_vld = 1'b0;
    shift_bits(8'h3C, 8, 0);
    send_par(1'b0, 0);
    chk("restart_busy", 32'(busy), 32'h1);
    tick;
    chk("restart_key_out", 32'(key_out), 32'h3C);
    chk("restart_ready", 32'(key_ready), 32'h1);
    $display("restart: key_out=%02h ready=%0d", key_out, key_ready);

    // Re-provision from ARMED
    do_reset;
    send_frame(8'hA5, 1'b0, 0);
    tick;
    chk("reprov_armed", 32'(key_out), 32'hA5);
    start_pulse;
    chk("reprov_clear_out", 32'(key_out), 32'h0);
    chk("reprov_clear_ready", 32'(key_ready), 32'h0);
    chk("reprov_busy", 32'(busy), 32'h1);
    shift_bits(8'h0F, 8, 0);
    send_par(1'b0, 0);
    tick;
    chk("reprov_key_out", 32'(key_out), 32'h0F);
    chk("reprov_ready", 32'(key_ready), 32'h1);
    $display("reprovision: key_out=%02h ready=%0d", key_out, key_ready);

    // Start during CHECK is ignored
    send_frame(8'h81, 1'b0, 0);
    key_start = 1'b1;
    tick;
    key_start = 1'b0;
    chk("chkstart_key_out", 32'(key_out), 32'h81);
    chk("chkstart_ready", 32'(key_ready), 32'h1);
    chk("chkstart_busy", 32'(busy), 32'h0);
    $display("start in CHECK: key_out=%02h ready=%0d", key_out, key_ready);

    // Asynchronous reset mid-frame with sparse strobes
    start_pulse;
    shift_bits(8'hFF, 5, 2);
    chk("arst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_key_out", 32'(key_out), 32'h0);
    chk("arst_ready", 32'(key_ready), 32'h0);
    chk("arst_locked", 32'(locked), 32'h0);
    tick;
    rst = 1'b0;
    tick;
    send_frame(8'h5A, 1'b0, 2);
    tick;
    chk("arst_after_key_out", 32'(key_out), 32'h5A);
    chk("arst_after_ready", 32'(key_ready), 32'h1);
    $display("async reset mid-frame, then key_out=%02h ready=%0d", key_out, key_ready);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
